// File: rtl/stb_pkg.sv
// Shared definitions for the trace/stream memory stage that sits behind the Tracer.
package STB_PKG;

    localparam int unsigned TRB_WIDTH      = 32;
    localparam int unsigned TRB_DEPTH      = 64;
    localparam int unsigned TRB_DELAY_BITS = 16;

    localparam logic [1:0] trace_mode = 2'd0;

    typedef logic [$clog2(TRB_DEPTH)-1:0] trb_ptr_t;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DELAY,
        FROZEN
    } trb_phase_t;

endpackage

// File: rtl/trb_ring_ram.sv
// Simple dual-port word memory: one write port, one registered read port (block-RAM style).
module trb_ring_ram #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Read-first: a write and read of the same address returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_mem_ctrl.sv
// Trace/stream word memory behind the Tracer: circular trace buffer with delayed-trigger freeze,
// or a flow-controlled FIFO, plus the STORE/LOAD handshakes.
module trace_mem_ctrl
    import STB_PKG::*;
#(
    parameter int unsigned WIDTH      = TRB_WIDTH,
    parameter int unsigned DEPTH      = TRB_DEPTH,
    parameter int unsigned DELAY_BITS = TRB_DELAY_BITS
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RST_I,
    input  logic [1:0]               MODE_I,
    input  logic                     TRG_EVENT_I,
    input  logic [DELAY_BITS-1:0]    TRG_DELAY_I,
    output logic                     TRG_DELAYED_O,
    input  logic [WIDTH-1:0]         DATA_I,
    input  logic                     STORE_I,
    output logic                     STORE_PERM_O,
    input  logic                     LOAD_REQUEST_I,
    output logic                     LOAD_GRANT_O,
    output logic [WIDTH-1:0]         DATA_O,
    output logic [$clog2(DEPTH):0]   FILL_O,
    output logic                     OVERFLOW_O
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [1:0]            mode_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DELAY_BITS-1:0] delay_q, delay_d;
    trb_phase_t            phase_q, phase_d;
    logic                  overflow_q, overflow_d;
    logic                  grant_q, grant_d;
    logic [WIDTH-1:0]      hold_q, hold_d;
    logic [WIDTH-1:0]      ram_rdata;

    logic stream, full, flush, store_acc, grant_dec;

    assign stream        = (mode_q != trace_mode);
    assign full          = (count_q == FullCnt);
    assign flush         = (MODE_I != mode_q);
    assign STORE_PERM_O  = stream ? !full : (phase_q != FROZEN);
    assign TRG_DELAYED_O = (phase_q == FROZEN);
    assign FILL_O        = count_q;
    assign OVERFLOW_O    = overflow_q;
    assign LOAD_GRANT_O  = grant_q;
    // The RAM read port lands in the grant cycle; afterwards the captured copy is held.
    assign DATA_O        = grant_q ? ram_rdata : hold_q;

    assign store_acc = STORE_I && STORE_PERM_O && !flush;
    assign grant_dec = LOAD_REQUEST_I && !grant_q && (!stream || (count_q != '0));

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        delay_d    = delay_q;
        phase_d    = phase_q;
        overflow_d = overflow_q;
        grant_d    = grant_dec;
        hold_d     = grant_q ? ram_rdata : hold_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            delay_d    = '0;
            phase_d    = IDLE;
            overflow_d = 1'b0;
            grant_d    = 1'b0;
        end else begin
            if (store_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (stream) begin
                phase_d = IDLE;
                if (grant_dec) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                if (store_acc && !grant_dec) begin
                    count_d = count_q + CW'(1);
                end else if (!store_acc && grant_dec) begin
                    count_d = count_q - CW'(1);
                end
                if (STORE_I && full) begin
                    overflow_d = 1'b1;
                end
            end else begin
                // Reads track the write pointer so a load returns the oldest word.
                rd_ptr_d = wr_ptr_d;
                if (store_acc && !full) begin
                    count_d = count_q + CW'(1);
                end
                unique case (phase_q)
                    IDLE:   phase_d = ARMED;
                    ARMED: begin
                        if (TRG_EVENT_I) begin
                            phase_d = DELAY;
                            delay_d = TRG_DELAY_I;
                        end
                    end
                    DELAY: begin
                        if (delay_q == '0) begin
                            phase_d = FROZEN;
                        end else if (store_acc) begin
                            delay_d = delay_q - DELAY_BITS'(1);
                        end
                    end
                    FROZEN: phase_d = FROZEN;
                endcase
            end
        end
    end

    always_ff @(posedge FPGA_CLK_I) begin
        if (RST_I) begin
            mode_q     <= MODE_I;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            delay_q    <= '0;
            phase_q    <= IDLE;
            overflow_q <= 1'b0;
            grant_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            mode_q     <= MODE_I;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            delay_q    <= delay_d;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
            grant_q    <= grant_d;
            hold_q     <= hold_d;
        end
    end

    trb_ring_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (FPGA_CLK_I),
        .we_i    (store_acc && !RST_I),
        .waddr_i (wr_ptr_q),
        .wdata_i (DATA_I),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_trace_mem_ctrl.sv
// Self-checking bench for trace_mem_ctrl (DEPTH=4); load data is checked through a scoreboard.
module tb_trace_mem_ctrl;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned DB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          trg_event;
    logic [DB-1:0] trg_delay;
    logic          trg_delayed;
    logic [W-1:0]  data_in;
    logic          store;
    logic          store_perm;
    logic          load_req;
    logic          load_grant;
    logic [W-1:0]  data_out;
    logic [2:0]    fill;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] sb[$];

    always #5 clk = ~clk;

    trace_mem_ctrl #(
        .WIDTH      (W),
        .DEPTH      (D),
        .DELAY_BITS (DB)
    ) dut (
        .FPGA_CLK_I     (clk),
        .RST_I          (rst),
        .MODE_I         (mode),
        .TRG_EVENT_I    (trg_event),
        .TRG_DELAY_I    (trg_delay),
        .TRG_DELAYED_O  (trg_delayed),
        .DATA_I         (data_in),
        .STORE_I        (store),
        .STORE_PERM_O   (store_perm),
        .LOAD_REQUEST_I (load_req),
        .LOAD_GRANT_O   (load_grant),
        .DATA_O         (data_out),
        .FILL_O         (fill),
        .OVERFLOW_O     (overflow)
    );

    // Every grant must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (load_grant) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_grant: got grant data=%h, required no grant", data_out);
            end else begin
                logic [W-1:0] exp_w;
                exp_w = sb.pop_front();
                if (data_out !== exp_w) begin
                    failures++;
                    $display("FAIL load_data: got %h, required %h", data_out, exp_w);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store_word(input logic [W-1:0] v);
        data_in = v;
        store   = 1'b1;
        tick();
        store   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; trg_event = 1'b0; trg_delay = '0;
        data_in = '0; store = 1'b0; load_req = 1'b0;
        tick(); tick();
        checks += 6;
        if (store_perm !== 1'b1) begin failures++; $display("FAIL rst_perm: got %b, required 1", store_perm); end
        if (trg_delayed !== 1'b0) begin failures++; $display("FAIL rst_trg: got %b, required 0", trg_delayed); end
        if (load_grant !== 1'b0) begin failures++; $display("FAIL rst_grant: got %b, required 0", load_grant); end
        if (data_out !== '0) begin failures++; $display("FAIL rst_data: got %h, required 0", data_out); end
        if (fill !== 3'd0) begin failures++; $display("FAIL rst_fill: got %0d, required 0", fill); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b, required 0", overflow); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stream_fill_drain();
        logic [W-1:0] vals [4];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44};
        mode = 2'd1;
        tick();
        for (int i = 0; i < 4; i++) store_word(vals[i]);
        checks += 2;
        if (fill !== 3'd4) begin failures++; $display("FAIL sfd_fill_full: got %0d, required 4", fill); end
        if (store_perm !== 1'b0) begin failures++; $display("FAIL sfd_perm_full: got %b, required 0", store_perm); end
        store_word(32'h55);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL sfd_overflow: got %b, required 1", overflow); end
        for (int i = 0; i < 4; i++) begin
            load_req = 1'b1;
            sb.push_back(vals[i]);
            tick();
            load_req = 1'b0;
            tick();
        end
        checks++;
        if (fill !== 3'd0) begin failures++; $display("FAIL sfd_fill_empty: got %0d, required 0", fill); end
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        checks++;
        if (load_grant !== 1'b0) begin failures++; $display("FAIL sfd_empty_grant: got %b, required 0", load_grant); end
        tick();
    endtask

    task automatic test_concurrent();
        store_word(32'hA1);
        store_word(32'hA2);
        data_in  = 32'hA3;
        store    = 1'b1;
        load_req = 1'b1;
        sb.push_back(32'hA1);
        tick();
        store    = 1'b0;
        load_req = 1'b0;
        checks++;
        if (fill !== 3'd2) begin failures++; $display("FAIL conc_fill: got %0d, required 2", fill); end
        tick();
        for (int i = 0; i < 2; i++) begin
            load_req = 1'b1;
            sb.push_back(i == 0 ? 32'hA2 : 32'hA3);
            tick();
            load_req = 1'b0;
            tick();
        end
        checks++;
        if (fill !== 3'd0) begin failures++; $display("FAIL conc_drain: got %0d, required 0", fill); end
    endtask

    task automatic test_trigger_delay();
        mode = 2'd0;
        trg_event = 1'b0;
        trg_delay = 16'd3;
        tick();
        tick();
        for (int i = 0; i < 6; i++) store_word(W'(i));
        trg_event = 1'b1;
        tick();
        for (int i = 6; i < 9; i++) store_word(W'(i));
        checks += 2;
        if (trg_delayed !== 1'b0) begin failures++; $display("FAIL trg_early: got %b, required 0", trg_delayed); end
        if (store_perm !== 1'b1) begin failures++; $display("FAIL trg_perm_early: got %b, required 1", store_perm); end
        tick();
        checks += 2;
        if (trg_delayed !== 1'b1) begin failures++; $display("FAIL trg_frozen: got %b, required 1", trg_delayed); end
        if (store_perm !== 1'b0) begin failures++; $display("FAIL trg_perm_frozen: got %b, required 0", store_perm); end
        store_word(32'd9);
        checks++;
        if (fill !== 3'd4) begin failures++; $display("FAIL trg_fill: got %0d, required 4", fill); end
        // Oldest of the last four words (5..8); word 9 must not have overwritten it.
        load_req = 1'b1;
        sb.push_back(32'd5);
        tick();
        load_req = 1'b0;
        tick();
    endtask

    task automatic test_zero_delay_wrap();
        trg_event = 1'b0;
        mode = 2'd1;
        tick();
        mode = 2'd0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) store_word(W'(i));
        trg_delay = '0;
        trg_event = 1'b1;
        tick();
        checks++;
        if (trg_delayed !== 1'b0) begin failures++; $display("FAIL zd_delay_state: got %b, required 0", trg_delayed); end
        tick();
        checks += 2;
        if (trg_delayed !== 1'b1) begin failures++; $display("FAIL zd_frozen: got %b, required 1", trg_delayed); end
        if (fill !== 3'd4) begin failures++; $display("FAIL zd_fill: got %0d, required 4", fill); end
        load_req = 1'b1;
        sb.push_back(32'd2);
        tick();
        load_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        load_req = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(32'd2);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks += 2;
            if (load_grant !== ((i % 2) == 0)) begin
                failures++;
                $display("FAIL b2b_grant_%0d: got %b, required %b", i, load_grant, (i % 2) == 0);
            end
            if (data_out !== 32'd2) begin
                failures++;
                $display("FAIL b2b_data_%0d: got %h, required 2", i, data_out);
            end
        end
        load_req = 1'b0;
        tick();
    endtask

    task automatic test_flush_reset();
        mode = 2'd1;
        tick();
        checks += 4;
        if (fill !== 3'd0) begin failures++; $display("FAIL fl_frz_fill: got %0d, required 0", fill); end
        if (trg_delayed !== 1'b0) begin failures++; $display("FAIL fl_frz_trg: got %b, required 0", trg_delayed); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL fl_frz_ovf: got %b, required 0", overflow); end
        if (store_perm !== 1'b1) begin failures++; $display("FAIL fl_frz_perm: got %b, required 1", store_perm); end
        for (int i = 0; i < 5; i++) store_word(32'hC0 + W'(i));
        checks++;
        if (overflow !== 1'b1 || fill !== 3'd4) begin
            failures++;
            $display("FAIL fl_full_pre: got ovf=%b fill=%0d, required ovf=1 fill=4", overflow, fill);
        end
        mode = 2'd0;
        tick();
        checks += 3;
        if (fill !== 3'd0) begin failures++; $display("FAIL fl_full_fill: got %0d, required 0", fill); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL fl_full_ovf: got %b, required 0", overflow); end
        if (trg_delayed !== 1'b0) begin failures++; $display("FAIL fl_full_trg: got %b, required 0", trg_delayed); end
        // Reset asserted during the grant cycle.
        load_req = 1'b1;
        sb.push_back(32'hC0);
        tick();
        load_req = 1'b0;
        rst = 1'b1;
        tick();
        checks += 2;
        if (load_grant !== 1'b0) begin failures++; $display("FAIL rstg_grant: got %b, required 0", load_grant); end
        if (data_out !== '0) begin failures++; $display("FAIL rstg_data: got %h, required 0", data_out); end
        // Request made while reset is held must not produce a grant.
        load_req = 1'b1;
        tick();
        rst = 1'b0;
        load_req = 1'b0;
        tick();
        checks++;
        if (load_grant !== 1'b0) begin failures++; $display("FAIL rstd_grant: got %b, required 0", load_grant); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream_fill_drain();
        test_concurrent();
        test_trigger_delay();
        test_zero_delay_wrap();
        test_back_to_back();
        test_flush_reset();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
